// File: rtl/spi_arbiter.sv
// Two-requester arbiter in front of one SPI engine; alternates on ties, one transfer in flight.
// Launch one cycle after accept; response holds until the owner's rready, and no new request is taken meanwhile.
module spi_arbiter #(
  parameter logic [7:0] IFG_VAL      = 8'd4,
  parameter logic [7:0] CS_SCK_VAL   = 8'd2,
  parameter logic [7:0] SCK_CS_VAL   = 8'd2,
  parameter int         BUSY_TIMEOUT = 16
) (
  input  logic        GCLK,
  input  logic        RST,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [1:0]  r0_mode,
  input  logic [1:0]  r0_speed,
  input  logic [1:0]  r0_len,
  input  logic [31:0] r0_data,
  output logic        r0_rvalid,
  input  logic        r0_rready,
  output logic [31:0] r0_rdata,
  output logic        r0_rerr,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [1:0]  r1_mode,
  input  logic [1:0]  r1_speed,
  input  logic [1:0]  r1_len,
  input  logic [31:0] r1_data,
  output logic        r1_rvalid,
  input  logic        r1_rready,
  output logic [31:0] r1_rdata,
  output logic        r1_rerr,
  output logic        spi_start,
  input  logic        spi_busy,
  output logic [1:0]  spi_mode,
  output logic [1:0]  spi_speed,
  output logic [1:0]  spi_len,
  output logic [7:0]  spi_ifg,
  output logic [7:0]  spi_cs_sck,
  output logic [7:0]  spi_sck_cs,
  output logic [31:0] spi_mosi,
  input  logic [31:0] spi_miso,
  output logic        ctl_busy
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(BUSY_TIMEOUT - 1);

  state_t      state;
  logic        last_q;
  logic        owner_q;
  logic        start_q;
  logic        rvalid_q;
  logic        rerr_q;
  logic [31:0] rdata_q;
  logic [31:0] mosi_q;
  logic [1:0]  mode_q;
  logic [1:0]  speed_q;
  logic [1:0]  len_q;
  logic [7:0]  cnt_q;

  logic gnt_vld;
  logic gnt_sel;
  logic accept;
  logic resp_hs;

  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt_vld = r0_valid | r1_valid;
    gnt_sel = 1'b0;
    if (r0_valid && r1_valid) gnt_sel = ~last_q;
    else                      gnt_sel = r1_valid;
  end

  // Gating with RST keeps ready low while reset is held even though state already reads IDLE.
  assign accept   = RST && (state == IDLE) && gnt_vld;
  assign r0_ready = accept & ~gnt_sel;
  assign r1_ready = accept & gnt_sel;
  assign resp_hs  = rvalid_q && (owner_q ? r1_rready : r0_rready);

  always_ff @(posedge GCLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      start_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
      mosi_q   <= '0;
      mode_q   <= '0;
      speed_q  <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
    end else begin
      start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            owner_q <= gnt_sel;
            mode_q  <= gnt_sel ? r1_mode  : r0_mode;
            speed_q <= gnt_sel ? r1_speed : r0_speed;
            len_q   <= gnt_sel ? r1_len   : r0_len;
            mosi_q  <= gnt_sel ? r1_data  : r0_data;
            start_q <= 1'b1;
            state   <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt_q <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (spi_busy) begin
            state <= WAIT_DONE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            rdata_q  <= '0;
            rerr_q   <= 1'b1;
            rvalid_q <= 1'b1;
            state    <= RESP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!spi_busy) begin
            rdata_q  <= spi_miso;
            rerr_q   <= 1'b0;
            rvalid_q <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          if (resp_hs) begin
            rvalid_q <= 1'b0;
            last_q   <= owner_q;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign r0_rvalid  = rvalid_q & ~owner_q;
  assign r1_rvalid  = rvalid_q & owner_q;
  assign r0_rdata   = rdata_q;
  assign r1_rdata   = rdata_q;
  assign r0_rerr    = rerr_q;
  assign r1_rerr    = rerr_q;
  assign spi_start  = start_q;
  assign spi_mode   = mode_q;
  assign spi_speed  = speed_q;
  assign spi_len    = len_q;
  assign spi_mosi   = mosi_q;
  assign spi_ifg    = IFG_VAL;
  assign spi_cs_sck = CS_SCK_VAL;
  assign spi_sck_cs = SCK_CS_VAL;
  assign ctl_busy   = (state != IDLE);

endmodule

// File: tb/tb_spi_arbiter.sv
// Randomized bench for spi_arbiter: requesters and SPI engine are modelled as timed behaviours,
// expected grant order, response latency and response data are computed from the arbitration rules.
module tb_spi_arbiter;
  localparam int TO = 16;

  logic        GCLK = 1'b0;
  logic        RST  = 1'b0;
  logic        r0_valid, r0_ready, r0_rvalid, r0_rready, r0_rerr;
  logic [1:0]  r0_mode, r0_speed, r0_len;
  logic [31:0] r0_data, r0_rdata;
  logic        r1_valid, r1_ready, r1_rvalid, r1_rready, r1_rerr;
  logic [1:0]  r1_mode, r1_speed, r1_len;
  logic [31:0] r1_data, r1_rdata;
  logic        spi_start, spi_busy, ctl_busy;
  logic [1:0]  spi_mode, spi_speed, spi_len;
  logic [7:0]  spi_ifg, spi_cs_sck, spi_sck_cs;
  logic [31:0] spi_mosi, spi_miso;

  spi_arbiter #(
    .IFG_VAL(8'd4), .CS_SCK_VAL(8'd2), .SCK_CS_VAL(8'd2), .BUSY_TIMEOUT(TO)
  ) dut (
    .GCLK(GCLK), .RST(RST),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_mode(r0_mode), .r0_speed(r0_speed),
    .r0_len(r0_len), .r0_data(r0_data), .r0_rvalid(r0_rvalid), .r0_rready(r0_rready),
    .r0_rdata(r0_rdata), .r0_rerr(r0_rerr),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_mode(r1_mode), .r1_speed(r1_speed),
    .r1_len(r1_len), .r1_data(r1_data), .r1_rvalid(r1_rvalid), .r1_rready(r1_rready),
    .r1_rdata(r1_rdata), .r1_rerr(r1_rerr),
    .spi_start(spi_start), .spi_busy(spi_busy), .spi_mode(spi_mode), .spi_speed(spi_speed),
    .spi_len(spi_len), .spi_ifg(spi_ifg), .spi_cs_sck(spi_cs_sck), .spi_sck_cs(spi_sck_cs),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .ctl_busy(ctl_busy)
  );

  always #5 GCLK = ~GCLK;

  int n_chk = 0;
  int n_err = 0;

  // Requester model: a pending request keeps valid high with fixed fields until accepted.
  bit          pend[2];
  logic [1:0]  pmode[2], pspeed[2], plen[2];
  logic [31:0] pdata[2];
  int          last_srv = 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic new_req(input int n);
    pend[n]   = 1'b1;
    pmode[n]  = 2'($urandom);
    pspeed[n] = 2'($urandom);
    plen[n]   = 2'($urandom);
    pdata[n]  = $urandom;
  endtask

  task automatic drive_inputs();
    r0_valid = pend[0]; r0_mode = pmode[0]; r0_speed = pspeed[0]; r0_len = plen[0]; r0_data = pdata[0];
    r1_valid = pend[1]; r1_mode = pmode[1]; r1_speed = pspeed[1]; r1_len = plen[1]; r1_data = pdata[1];
  endtask

  // Called just after a falling edge with the arbiter idle; returns just after a falling edge.
  task automatic run_txn(input bit force_never);
    int          win, exp_t, d, len_busy, hold, got_t;
    bit          never;
    logic [31:0] miso, got_data;
    if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
    drive_inputs();
    #1;
    win = (pend[0] && pend[1]) ? (last_srv == 1 ? 0 : 1) : (pend[1] ? 1 : 0);
    check("grant_r0", 32'(r0_ready), 32'(win == 0));
    check("grant_r1", 32'(r1_ready), 32'(win == 1));
    never    = force_never || ($urandom_range(0, 4) == 0);
    d        = int'($urandom_range(1, 5));
    len_busy = int'($urandom_range(1, 6));
    miso     = $urandom;
    spi_miso = miso;

    @(negedge GCLK);
    pend[win] = 1'b0;
    drive_inputs();
    #1;
    check("start_high", 32'(spi_start), 32'd1);
    check("spi_mode", 32'(spi_mode), 32'(pmode[win]));
    check("spi_speed", 32'(spi_speed), 32'(pspeed[win]));
    check("spi_len", 32'(spi_len), 32'(plen[win]));
    check("spi_mosi", spi_mosi, pdata[win]);
    check("busy_launch", 32'(ctl_busy), 32'd1);
    check("no_ready_launch", 32'(r0_ready | r1_ready), 32'd0);

    // Engine raises busy d cycles after start for len_busy cycles; the response lands the cycle after busy falls.
    exp_t = never ? TO + 1 : d + len_busy + 1;
    got_t = 0;
    for (int t = 1; t <= 60 && got_t == 0; t++) begin
      @(negedge GCLK);
      spi_busy = !never && (t >= d) && (t < d + len_busy);
      #1;
      if (t == 1) check("start_pulse_end", 32'(spi_start), 32'd0);
      if (r0_rvalid || r1_rvalid) got_t = t;
    end
    spi_busy = 1'b0;
    check("resp_latency", 32'(got_t), 32'(exp_t));
    check("rvalid_r0", 32'(r0_rvalid), 32'(win == 0));
    check("rvalid_r1", 32'(r1_rvalid), 32'(win == 1));
    got_data = (win == 1) ? r1_rdata : r0_rdata;
    check("rdata", got_data, never ? 32'd0 : miso);
    check("rerr", 32'((win == 1) ? r1_rerr : r0_rerr), 32'(never));
    spi_miso = $urandom;

    hold = int'($urandom_range(0, 10));
    repeat (hold) begin
      @(negedge GCLK);
      if (!pend[0]) r0_valid = 1'($urandom);
      if (!pend[1]) r1_valid = 1'($urandom);
      r0_rready = (win == 1) ? 1'($urandom) : 1'b0;
      r1_rready = (win == 0) ? 1'($urandom) : 1'b0;
      #1;
      check("hold_rvalid", 32'((win == 1) ? r1_rvalid : r0_rvalid), 32'd1);
      check("hold_rdata", (win == 1) ? r1_rdata : r0_rdata, got_data);
      check("hold_ctl_busy", 32'(ctl_busy), 32'd1);
      check("hold_no_grant", 32'(r0_ready | r1_ready), 32'd0);
    end

    @(negedge GCLK);
    drive_inputs();
    r0_rready = (win == 0);
    r1_rready = (win == 1);
    @(negedge GCLK);
    r0_rready = 1'b0;
    r1_rready = 1'b0;
    last_srv  = win;
    #1;
    check("rvalid_drop", 32'(r0_rvalid | r1_rvalid), 32'd0);
    check("idle_after_resp", 32'(ctl_busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rst_leak;
    r0_rready = 1'b0;
    r1_rready = 1'b0;
    spi_busy  = 1'b0;
    spi_miso  = '0;
    new_req(0);
    new_req(1);
    drive_inputs();
    repeat (3) @(negedge GCLK);
    #1;
    check("rst_ready", 32'(r0_ready | r1_ready), 32'd0);
    check("rst_ctl_busy", 32'(ctl_busy), 32'd0);
    check("rst_start", 32'(spi_start), 32'd0);
    check("rst_rvalid", 32'(r0_rvalid | r1_rvalid), 32'd0);
    check("rst_rdata", r0_rdata, 32'd0);
    check("rst_rerr", 32'(r0_rerr | r1_rerr), 32'd0);
    check("rst_mosi", spi_mosi, 32'd0);
    check("rst_cfg", 32'({spi_mode, spi_speed, spi_len}), 32'd0);
    check("ifg", 32'(spi_ifg), 32'd4);
    check("cs_sck", 32'(spi_cs_sck), 32'd2);
    check("sck_cs", 32'(spi_sck_cs), 32'd2);

    @(negedge GCLK);
    RST = 1'b1;
    for (int i = 0; i < 40; i++) begin
      for (int n = 0; n < 2; n++)
        if (!pend[n] && $urandom_range(0, 2) == 0) new_req(n);
      run_txn(1'b0);
    end

    // Abandon a transfer while the engine is busy.
    if (!pend[0] && !pend[1]) new_req(0);
    drive_inputs();
    @(negedge GCLK);
    for (int t = 1; t <= 5; t++) begin
      @(negedge GCLK);
      spi_busy = (t >= 2);
    end
    #1;
    check("pre_rst_busy", 32'(ctl_busy), 32'd1);
    #1;
    RST = 1'b0;
    #1;
    check("mid_rst_ctl_busy", 32'(ctl_busy), 32'd0);
    check("mid_rst_start", 32'(spi_start), 32'd0);
    check("mid_rst_ready", 32'(r0_ready | r1_ready), 32'd0);
    check("mid_rst_rvalid", 32'(r0_rvalid | r1_rvalid), 32'd0);
    check("mid_rst_rdata", r1_rdata, 32'd0);
    check("mid_rst_mosi", spi_mosi, 32'd0);
    pend[0]  = 1'b0;
    pend[1]  = 1'b0;
    spi_busy = 1'b0;
    drive_inputs();
    @(negedge GCLK);
    RST = 1'b1;
    rst_leak = 0;
    repeat (6) begin
      @(negedge GCLK);
      #1;
      if (r0_rvalid || r1_rvalid || ctl_busy) rst_leak++;
    end
    check("no_resp_after_rst", 32'(rst_leak), 32'd0);

    // Pointer is back at its reset value: r0 wins the tie, then r1 times out.
    last_srv = 1;
    new_req(0);
    new_req(1);
    run_txn(1'b0);
    run_txn(1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
